// File: rtl/serial_wide_comparator_ctrl.sv
// ---------------------------------------------------------------------------
// serial_wide_comparator_ctrl
//
// Compares two wide operands (W = SLICE_W*NUM_SLICES bits) by walking a
// single SLICE_W-bit compare slice across the operands, least-significant
// slice first, one slice per clock. The greater/equal/less result of each
// slice is carried into the next one, so the most significant slice that
// differs decides the final answer.
//
// Build option:
//   SIGNED_CMP_EN  when defined, the operands are two's complement. The MSB
//                  of both top-slice chunks is inverted before comparison.
//                  FSM and timing do not change.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   start_valid    requester presents a job        (in)
//   start_ready    controller can accept a job     (out, decoded from state)
//   a, b           operands, captured on the start handshake
//   result_valid   agtb/aeqb/altb hold a finished compare
//   result_ready   consumer accepts the result
//   agtb/aeqb/altb three-way result, registered
//   busy           job in flight (RUN or DONE)
//
// Handshakes: a transfer happens on the rising edge where valid && ready.
// A producer holds valid (and its data) until that edge. start_ready depends
// only on the state (and on rst). result_valid and the result outputs are
// registered and do not depend on result_ready.
// ---------------------------------------------------------------------------
module serial_wide_comparator_ctrl #(
   parameter  int SLICE_W    = 4,
   parameter  int NUM_SLICES = 8,
   localparam int W          = SLICE_W * NUM_SLICES,
   localparam int IW         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_valid,
   output logic         start_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         result_valid,
   input  logic         result_ready,
   output logic         agtb,
   output logic         aeqb,
   output logic         altb,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [IW-1:0] LAST = IW'(NUM_SLICES - 1);

   state_t          state;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [IW-1:0]   idx;
   logic            gt_q;
   logic            eq_q;
   logic            lt_q;

   logic [SLICE_W-1:0] as;
   logic [SLICE_W-1:0] bs;
   logic               slice_gt;
   logic               slice_eq;
   logic               slice_lt;

   // Gating with rst keeps start_ready low for the whole reset pulse.
   assign start_ready = (state == IDLE) && !rst;

   assign agtb = gt_q;
   assign aeqb = eq_q;
   assign altb = lt_q;

   // Current slice compare.
   always_comb begin
      as = a_q[idx*SLICE_W +: SLICE_W];
      bs = b_q[idx*SLICE_W +: SLICE_W];
`ifdef SIGNED_CMP_EN
      // Flipping the sign bit maps two's complement ordering onto unsigned
      // ordering. Only the top slice carries the sign.
      if (idx == LAST) begin
         as[SLICE_W-1] = ~as[SLICE_W-1];
         bs[SLICE_W-1] = ~bs[SLICE_W-1];
      end
`endif
      slice_gt = (as > bs);
      slice_eq = (as == bs);
      slice_lt = (as < bs);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         idx          <= '0;
         gt_q         <= 1'b0;
         eq_q         <= 1'b0;
         lt_q         <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  idx   <= '0;
                  // Empty lower part compares as "equal".
                  gt_q  <= 1'b0;
                  eq_q  <= 1'b1;
                  lt_q  <= 1'b0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               // A differing slice overrides everything below it. An equal
               // slice passes the lower result through.
               gt_q <= slice_gt | (slice_eq & gt_q);
               eq_q <= slice_eq & eq_q;
               lt_q <= slice_lt | (slice_eq & lt_q);
               if (idx == LAST) begin
                  result_valid <= 1'b1;
                  state        <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_wide_comparator_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_wide_comparator_ctrl
//
// Directed bench for serial_wide_comparator_ctrl. The driver issues jobs and
// pushes the hand-computed result ({agtb,aeqb,altb}) into exp_q. A monitor
// pops exp_q on every result handshake. It also checks latency, one-hot
// results and output stability under backpressure. A second instance
// (SLICE_W=8, NUM_SLICES=1) covers the single-slice configuration.
// ---------------------------------------------------------------------------
module tb_serial_wide_comparator_ctrl;

   localparam int SW = 4;
   localparam int NS = 8;
   localparam int W  = SW * NS;

   localparam logic [2:0] R_GT = 3'b100;
   localparam logic [2:0] R_EQ = 3'b010;
   localparam logic [2:0] R_LT = 3'b001;

`ifdef SIGNED_CMP_EN
   localparam logic [2:0] R_SIGN = R_LT;   // 0x80000000 is negative
`else
   localparam logic [2:0] R_SIGN = R_GT;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- main DUT ----------------
   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         result_valid;
   logic         result_ready;
   logic         agtb;
   logic         aeqb;
   logic         altb;
   logic         busy;

   serial_wide_comparator_ctrl #(.SLICE_W(SW), .NUM_SLICES(NS)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .a            (a),
      .b            (b),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .agtb         (agtb),
      .aeqb         (aeqb),
      .altb         (altb),
      .busy         (busy)
   );

   // ---------------- single-slice DUT ----------------
   logic       s1_start_valid;
   logic       s1_start_ready;
   logic [7:0] s1_a;
   logic [7:0] s1_b;
   logic       s1_result_valid;
   logic       s1_result_ready;
   logic       s1_agtb;
   logic       s1_aeqb;
   logic       s1_altb;
   logic       s1_busy;

   serial_wide_comparator_ctrl #(.SLICE_W(8), .NUM_SLICES(1)) dut1 (
      .clk          (clk),
      .rst          (rst),
      .start_valid  (s1_start_valid),
      .start_ready  (s1_start_ready),
      .a            (s1_a),
      .b            (s1_b),
      .result_valid (s1_result_valid),
      .result_ready (s1_result_ready),
      .agtb         (s1_agtb),
      .aeqb         (s1_aeqb),
      .altb         (s1_altb),
      .busy         (s1_busy)
   );

   // ---------------- scoreboard ----------------
   int         checks = 0;
   int         errors = 0;
   logic [2:0] exp_q[$];
   int         acc_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // ---------------- monitor ----------------
   logic       prev_valid = 1'b0;
   logic       prev_hold  = 1'b0;
   logic [2:0] prev_out   = 3'b000;
   logic [2:0] cur_out;
   logic [2:0] exp_res;
   int         acc_cyc;

   always @(negedge clk) begin
      cur_out = {agtb, aeqb, altb};
      if (rst) begin
         prev_valid = 1'b0;
         prev_hold  = 1'b0;
      end else begin
         if (start_valid && start_ready)
            acc_q.push_back(cyc);
         if (result_valid) begin
            if (!prev_valid) begin
               if (acc_q.size() == 0) begin
                  fail_now("latency_no_accept");
               end else begin
                  acc_cyc = acc_q.pop_front();
                  check("latency", cyc - acc_cyc, NS + 1);
               end
               check("onehot", $countones(cur_out), 1);
            end
            if (prev_hold) begin
               check("stable_out", cur_out, prev_out);
               check("ready_low_in_done", start_ready, 1'b0);
            end
            if (result_ready) begin
               if (exp_q.size() == 0) begin
                  fail_now("unexpected_result");
               end else begin
                  exp_res = exp_q.pop_front();
                  check("result", cur_out, exp_res);
               end
            end
            prev_hold = !result_ready;
            prev_out  = cur_out;
         end else begin
            prev_hold = 1'b0;
         end
         prev_valid = result_valid;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic run_job(input logic [W-1:0] ja, input logic [W-1:0] jb, input logic [2:0] exp_r);
      int n;
      n = 0;
      start_valid = 1'b1;
      a = ja;
      b = jb;
      forever begin
         @(negedge clk);
         if (start_ready) break;
         n++;
         if (n > 200) begin
            fail_now("accept_timeout");
            start_valid = 1'b0;
            return;
         end
      end
      exp_q.push_back(exp_r);
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      // Scramble operands after the handshake; the job must not see this.
      a = W'($urandom);
      b = W'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (n >= 500) fail_now("drain_timeout");
      #1;
   endtask

   task automatic wait_result_valid();
      int n;
      n = 0;
      while (!result_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) fail_now("result_valid_timeout");
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      start_valid     = 1'b0;
      a               = '0;
      b               = '0;
      result_ready    = 1'b1;
      s1_start_valid  = 1'b0;
      s1_a            = '0;
      s1_b            = '0;
      s1_result_ready = 1'b1;

      // Reset values.
      repeat (3) @(posedge clk);
      #1;
      check("rst_start_ready", start_ready, 1'b0);
      check("rst_result_valid", result_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_outputs", {agtb, aeqb, altb}, 3'b000);
      check("rst_s1_start_ready", s1_start_ready, 1'b0);
      rst = 1'b0;
      #1;
      check("idle_start_ready", start_ready, 1'b1);

      // Main function, back-to-back jobs.
      run_job(32'h1234_5678, 32'h1234_5678, R_EQ);
      run_job(32'h0000_0010, 32'h0000_0001, R_GT);
      run_job(32'hFFFF_FFF0, 32'hFFFF_FFFF, R_LT);
      run_job(32'h8000_0000, 32'h7FFF_FFFF, R_SIGN);
      run_job(32'hFFFF_FFFF, 32'h0000_0000, R_SIGN);
      run_job(32'h0000_0000, 32'h0000_0000, R_EQ);
      run_job(32'h0001_0000, 32'h0000_FFFF, R_GT);
      run_job(32'h7000_0000, 32'h7000_0001, R_LT);
      drain();

      // Backpressure: result held 5 cycles while a new job is offered.
      run_job(32'h0000_0003, 32'h0000_0007, R_LT);
      result_ready = 1'b0;
      start_valid  = 1'b1;
      a = 32'h0000_0009;
      b = 32'h0000_0002;
      wait_result_valid();
      repeat (5) begin
         @(negedge clk);
         check("bp_start_ready", start_ready, 1'b0);
         check("bp_result_valid", result_valid, 1'b1);
      end
      @(posedge clk);
      #1;
      result_ready = 1'b1;
      run_job(32'h0000_0009, 32'h0000_0002, R_GT);
      drain();

      // Reset during slice 3.
      start_valid = 1'b1;
      a = 32'hFFFF_0000;
      b = 32'h0000_0001;
      n = 0;
      forever begin
         @(negedge clk);
         if (start_ready || n > 50) break;
         n++;
      end
      if (n > 50) fail_now("rst_job_accept_timeout");
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      exp_q.delete();
      acc_q.delete();
      check("midrst_result_valid", result_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_outputs", {agtb, aeqb, altb}, 3'b000);
      check("midrst_start_ready", start_ready, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      run_job(32'h0000_0005, 32'h0000_0009, R_LT);
      drain();

      // Single-slice instance: a=0xA5, b=0xA4.
      s1_start_valid = 1'b1;
      s1_a = 8'hA5;
      s1_b = 8'hA4;
      n = 0;
      forever begin
         @(negedge clk);
         if (s1_start_ready || n > 50) break;
         n++;
      end
      if (n > 50) fail_now("s1_accept_timeout");
      @(posedge clk);
      #1;
      s1_start_valid = 1'b0;
      s1_a = 8'h00;
      s1_b = 8'hFF;
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if (s1_result_valid || n > 20) break;
      end
      check("s1_latency", n, 2);
      check("s1_result", {s1_agtb, s1_aeqb, s1_altb}, R_GT);
      repeat (2) @(posedge clk);
      #1;
      check("s1_back_idle", s1_busy, 1'b0);

      check("exp_q_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_wide_comparator_ctrl.md
# serial_wide_comparator_ctrl

Multi-cycle controller that compares two wide unsigned operands by sequencing a SLICE_W-bit cascadable compare slice over NUM_SLICES chunks, least-significant slice first, one slice per clock. It feeds each slice's greater/equal/less result into the next slice's cascade inputs. It sits between a requester issuing compare jobs over a valid/ready handshake and a consumer receiving the three-way result over a second valid/ready handshake. It lets the team compare operands of arbitrary width with a single narrow comparator instead of a wide combinational one.

## Interface
- SLICE_W, 4, width of one compare slice in bits (>=1)
- NUM_SLICES, 8, number of slices; operand width W = SLICE_W*NUM_SLICES (>=1)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high
- start_valid  input  1  requester presents a job
- start_ready  output  1  controller can accept a job
- a  input  W  operand A, sampled on start handshake
- b  input  W  operand B, sampled on start handshake
- result_valid  output  1  result outputs hold a finished compare
- result_ready  input  1  consumer accepts result
- agtb  output  1  A > B
- aeqb  output  1  A == B
- altb  output  1  A < B
- busy  output  1  high in RUN or DONE

## Operation
- FSM states are IDLE, RUN and DONE; reset state is IDLE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready, latch a and b into internal registers.
  - Clear slice index to 0 and preset cascade regs gt=0, eq=1, lt=0.
  - Go to RUN.
- RUN: each cycle, for slice i (bits [i*SLICE_W +: SLICE_W]):
  - gt' = (as>bs) | (as==bs & gt)
  - eq' = (as==bs) & eq
  - lt' = (as<bs) | (as==bs & lt)
  - Register gt', eq', lt'. If i==NUM_SLICES-1, go to DONE; otherwise i++.
- DONE:
  - result_valid=1; agtb/aeqb/altb = cascade regs.
  - On result_ready, go to IDLE. The cascade regs and outputs keep their value until the next job presets them.
- Exactly one of agtb/aeqb/altb is 1 whenever result_valid=1.
- start_valid is ignored outside IDLE. Operands changing after the handshake do not affect the job.
- Slice index register width is max(1, $clog2(NUM_SLICES)). The index never exceeds NUM_SLICES-1.
- NUM_SLICES=1 gives a single RUN cycle.
- Reset values: start_ready=0 while rst is high, then 1 in IDLE; result_valid=0, agtb=0, aeqb=0, altb=0, busy=0. Internal regs and index are 0.
- Reset mid-operation (RUN or DONE): asynchronously abort to IDLE with the reset values above. No partial result is ever presented.

## Timing
- Accept edge = cycle 0. RUN occupies cycles 1..NUM_SLICES. result_valid rises after the edge ending cycle NUM_SLICES, so latency is NUM_SLICES+1 cycles from accept to result_valid.
- Result outputs are registered and stay stable while result_valid=1 and result_ready=0.
- Result handshake completes on the edge where result_valid&&result_ready. start_ready rises on the following cycle (IDLE).
- Minimum job-to-job interval: NUM_SLICES+2 cycles with result_ready held high.
- No combinational path from any input to any output except start_ready, which is decoded from state only.

## Configuration
- SIGNED_CMP_EN defined:
  - Operands are two's complement W-bit values.
  - In the top slice (i=NUM_SLICES-1), the MSB of both a and b slices is inverted before comparison, giving signed ordering.
- SIGNED_CMP_EN undefined: all slices are compared unsigned.
- The macro affects only the top-slice compare; FSM and timing are identical in both builds.

## Test plan
- Equal operands: a=0x12345678, b=0x12345678, defaults → aeqb=1, agtb=altb=0, result_valid exactly 9 cycles after accept.
- Higher slice overrides lower: a=0x00000010, b=0x00000001 → agtb=1 (slice0 lt, slice1 gt). Also a=0xFFFFFFF0, b=0xFFFFFFFF → altb=1.
- Sign bit: a=0x80000000, b=0x7FFFFFFF → agtb=1 without SIGNED_CMP_EN; altb=1 with SIGNED_CMP_EN. With SIGNED_CMP_EN, a=0xFFFFFFFF (-1), b=0x00000000 → altb=1.
- Backpressure: hold result_ready=0 for 5 cycles in DONE while start_valid=1 with new operands → outputs stable, start_ready=0, no new job accepted. After result_ready=1, the next job's result reflects the new operands.
- Reset mid-RUN: assert rst during slice 3 → result_valid=0, busy=0, all outputs 0 immediately. After release, job a=0x5, b=0x9 → altb=1 at normal latency.
- Edge config NUM_SLICES=1, SLICE_W=8: a=0xA5, b=0xA4 → agtb=1, result_valid 2 cycles after accept.
